// File: rtl/wb_victim_cache.sv
// Fully-associative victim cache between the write-back dcache and memory.
// Swaps lines with the dcache on a miss, writes back dirty displaced lines, supports flush.
module wb_victim_cache #(
    parameter int VC_ENTRIES = 4,
    parameter int TAG_BITS   = 26,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lookup_req_i,
    input  logic [TAG_BITS-1:0]   lookup_addr_i,
    output logic                  lookup_valid_o,
    output logic                  lookup_hit_o,
    output logic [LINE_WIDTH-1:0] lookup_line_o,
    output logic                  lookup_dirty_o,
    input  logic                  insert_req_i,
    input  logic [TAG_BITS-1:0]   insert_addr_i,
    input  logic [LINE_WIDTH-1:0] insert_line_i,
    input  logic                  insert_dirty_i,
    output logic                  insert_ack_o,
    output logic                  vc2mem_req_o,
    output logic [TAG_BITS-1:0]   vc2mem_addr_o,
    output logic [LINE_WIDTH-1:0] vc2mem_line_o,
    input  logic                  mem2vc_ack_i,
    input  logic                  flush_i,
    output logic                  flush_done_o,
    output logic                  busy_o
);
    localparam int IDX_W = $clog2(VC_ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VC_ENTRIES - 1);

    typedef enum logic [2:0] {
        VC_IDLE,
        VC_WRITE_BACK,
        VC_FLUSH_SCAN,
        VC_FLUSH_WB,
        VC_FLUSH_DONE
    } vc_state_e;

    vc_state_e state;
    vc_state_e state_next;

    logic [VC_ENTRIES-1:0] valid_q;
    logic [VC_ENTRIES-1:0] dirty_q;
    logic [TAG_BITS-1:0]   tag_q  [VC_ENTRIES];
    logic [LINE_WIDTH-1:0] line_q [VC_ENTRIES];
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      scan_idx;
    logic [TAG_BITS-1:0]   wb_addr_q;
    logic [LINE_WIDTH-1:0] wb_line_q;

    logic             lk_hit;
    logic [IDX_W-1:0] lk_idx;
    logic             ins_match;
    logic [IDX_W-1:0] ins_match_idx;
    logic             has_free;
    logic [IDX_W-1:0] free_idx;

    // Descending scan so the lowest matching / free index wins.
    always_comb begin
        lk_hit        = 1'b0;
        lk_idx        = '0;
        ins_match     = 1'b0;
        ins_match_idx = '0;
        has_free      = 1'b0;
        free_idx      = '0;
        for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == lookup_addr_i) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
            if (valid_q[i] && tag_q[i] == insert_addr_i) begin
                ins_match     = 1'b1;
                ins_match_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    logic             do_flush;
    logic             do_lookup;
    logic             do_insert;
    logic             swap;
    logic             ins_evict;
    logic             ins_wb;
    logic [IDX_W-1:0] ins_idx;
    logic             ins_dirty_new;
    logic             mem_ack;
    logic             scan_last;
    logic             scan_dirty;

    always_comb begin
        do_flush      = (state == VC_IDLE) && flush_i;
        do_lookup     = (state == VC_IDLE) && !flush_i && lookup_req_i;
        do_insert     = (state == VC_IDLE) && !flush_i && insert_req_i;
        swap          = do_lookup && lk_hit;
        ins_idx       = rr_ptr;
        ins_evict     = 1'b0;
        ins_dirty_new = insert_dirty_i;
        if (swap) begin
            ins_idx = lk_idx;
        end else if (ins_match) begin
            ins_idx       = ins_match_idx;
            ins_dirty_new = insert_dirty_i | dirty_q[ins_match_idx];
        end else if (has_free) begin
            ins_idx = free_idx;
        end else begin
            ins_evict = 1'b1;
        end
        ins_wb     = do_insert && ins_evict && dirty_q[rr_ptr];
        mem_ack    = vc2mem_req_o && mem2vc_ack_i;
        scan_last  = (scan_idx == LAST_IDX);
        scan_dirty = valid_q[scan_idx] && dirty_q[scan_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= VC_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            VC_IDLE: begin
                if (do_flush)    state_next = VC_FLUSH_SCAN;
                else if (ins_wb) state_next = VC_WRITE_BACK;
            end
            VC_WRITE_BACK: if (mem_ack) state_next = VC_IDLE;
            VC_FLUSH_SCAN: begin
                if (scan_dirty)     state_next = VC_FLUSH_WB;
                else if (scan_last) state_next = VC_FLUSH_DONE;
            end
            VC_FLUSH_WB: begin
                if (mem_ack) state_next = scan_last ? VC_FLUSH_DONE : VC_FLUSH_SCAN;
            end
            VC_FLUSH_DONE: state_next = VC_IDLE;
            default:       state_next = VC_IDLE;
        endcase
    end

    assign busy_o        = (state != VC_IDLE);
    assign vc2mem_req_o  = (state == VC_WRITE_BACK) || (state == VC_FLUSH_WB);
    assign vc2mem_addr_o = wb_addr_q;
    assign vc2mem_line_o = wb_line_q;

    // Tag/line storage needs no reset: valid_q gates every use.
    always_ff @(posedge clk) begin
        if (do_insert) begin
            tag_q[ins_idx]  <= insert_addr_i;
            line_q[ins_idx] <= insert_line_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q        <= '0;
            dirty_q        <= '0;
            rr_ptr         <= '0;
            scan_idx       <= '0;
            wb_addr_q      <= '0;
            wb_line_q      <= '0;
            lookup_valid_o <= 1'b0;
            lookup_hit_o   <= 1'b0;
            lookup_line_o  <= '0;
            lookup_dirty_o <= 1'b0;
            insert_ack_o   <= 1'b0;
            flush_done_o   <= 1'b0;
        end else begin
            lookup_valid_o <= do_lookup;
            lookup_hit_o   <= swap;
            insert_ack_o   <= (do_insert && !ins_wb) || ((state == VC_WRITE_BACK) && mem_ack);
            flush_done_o   <= (state == VC_FLUSH_DONE);

            // A hit hands ownership to the dcache; the insert below may refill the slot.
            if (swap) begin
                lookup_line_o   <= line_q[lk_idx];
                lookup_dirty_o  <= dirty_q[lk_idx];
                valid_q[lk_idx] <= 1'b0;
            end
            if (do_insert) begin
                valid_q[ins_idx] <= 1'b1;
                dirty_q[ins_idx] <= ins_dirty_new;
                if (ins_evict) rr_ptr <= rr_ptr + 1'b1;
                if (ins_wb) begin
                    wb_addr_q <= tag_q[rr_ptr];
                    wb_line_q <= line_q[rr_ptr];
                end
            end

            if (do_flush) scan_idx <= '0;
            if (state == VC_FLUSH_SCAN) begin
                valid_q[scan_idx] <= 1'b0;
                dirty_q[scan_idx] <= 1'b0;
                if (scan_dirty) begin
                    wb_addr_q <= tag_q[scan_idx];
                    wb_line_q <= line_q[scan_idx];
                end else if (!scan_last) begin
                    scan_idx <= scan_idx + 1'b1;
                end
            end
            if ((state == VC_FLUSH_WB) && mem_ack && !scan_last) scan_idx <= scan_idx + 1'b1;
            if (state == VC_FLUSH_DONE) rr_ptr <= '0;
        end
    end
endmodule
